// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// State encodings, opcode/funct values and datapath mux select codes.
package mips_mc_pkg;

  // Controller states; the numeric values are visible on the debug state port
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEXEC = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } statetype;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Coarse ALU request from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_t;

  // True for every primary opcode this controller implements
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW)  ||
           (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_ADDI) ||
           (op == OP_ORI)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath signal bundle.
// MIPS_MC_MEMWAIT_EN adds the memready handshake from memory.
interface mips_mc_controller_if #(parameter int STATE_W = 4);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
`ifdef MIPS_MC_MEMWAIT_EN
  logic               memready;
`endif
  logic               pcen;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic               zeroext;
  logic [1:0]         pcsrc;
  logic [2:0]         alucontrol;
  logic               illegal;
  logic [STATE_W-1:0] state;

  // Controller side
  modport master (
`ifdef MIPS_MC_MEMWAIT_EN
    input  memready,
`endif
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, zeroext, pcsrc, alucontrol, illegal, state
  );

  // Datapath side
  modport slave (
`ifdef MIPS_MC_MEMWAIT_EN
    output memready,
`endif
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, zeroext, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's coarse ALU request plus funct to an ALU code,
// and flags whether funct is one of the supported R-type operations.
module mc_aludec
  import mips_mc_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_legal_o
);

  // Funct legality is independent of aluop so DECODE can use it directly
  always_comb begin
    funct_legal_o = 1'b1;
    case (funct_i)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal_o = 1'b1;
      default:                               funct_legal_o = 1'b0;
    endcase
  end

  // ALU code selection
  always_comb begin
    alucontrol_o = ALUCTL_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUCTL_ADD;
      ALUOP_SUB: alucontrol_o = ALUCTL_SUB;
      ALUOP_OR:  alucontrol_o = ALUCTL_OR;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_SUB:  alucontrol_o = ALUCTL_SUB;
          FN_AND:  alucontrol_o = ALUCTL_AND;
          FN_OR:   alucontrol_o = ALUCTL_OR;
          FN_SLT:  alucontrol_o = ALUCTL_SLT;
          default: alucontrol_o = ALUCTL_ADD;
        endcase
      end
      default:   alucontrol_o = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore FSM control unit for a multicycle MIPS datapath.
// Optional MIPS_MC_MEMWAIT_EN: FETCH/MEMRD/MEMWR stall until memready=1.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_mc_controller_if.master  bus
);

  statetype   state_q;
  aluop_t     aluop;
  logic [2:0] alu_ctl;
  logic       funct_legal;
  logic       decode_ok;
  logic       mem_ready;
  logic       pcen_c;
  logic       irwrite_c;
  logic       memwrite_c;
  logic       regwrite_c;

`ifdef MIPS_MC_MEMWAIT_EN
  assign mem_ready = bus.memready;
`else
  assign mem_ready = 1'b1;
`endif

  mc_aludec u_aludec (
    .aluop_i       (aluop),
    .funct_i       (bus.funct),
    .alucontrol_o  (alu_ctl),
    .funct_legal_o (funct_legal)
  );

  // An instruction proceeds past DECODE only with a known op and, for R-type, a known funct
  assign decode_ok = op_supported(bus.op) && ((bus.op != OP_RTYPE) || funct_legal);

  // State register with next-state selection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:   if (mem_ready) state_q <= DECODE;
        DECODE: begin
          if (!decode_ok) begin
            state_q <= FETCH;
          end else begin
            case (bus.op)
              OP_LW, OP_SW:    state_q <= MEMADR;
              OP_RTYPE:        state_q <= EXECUTE;
              OP_BEQ, OP_BNE:  state_q <= BRANCH;
              OP_ADDI, OP_ORI: state_q <= IMMEXEC;
              OP_J:            state_q <= JUMP;
              default:         state_q <= FETCH;
            endcase
          end
        end
        MEMADR:  state_q <= (bus.op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (mem_ready) state_q <= MEMWB;
        MEMWR:   if (mem_ready) state_q <= FETCH;
        EXECUTE: state_q <= ALUWB;
        IMMEXEC: state_q <= IMMWB;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Output decode from the current state (plus op/zero where the state needs it)
  always_comb begin
    pcen_c         = 1'b0;
    irwrite_c      = 1'b0;
    memwrite_c     = 1'b0;
    regwrite_c     = 1'b0;
    bus.iord       = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = ALUSRCB_B;
    bus.zeroext    = 1'b0;
    bus.pcsrc      = PCSRC_ALU;
    bus.illegal    = 1'b0;
    aluop          = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        irwrite_c   = mem_ready;
        pcen_c      = mem_ready;
        bus.alusrcb = ALUSRCB_FOUR;
      end
      DECODE: begin
        bus.alusrcb = ALUSRCB_BRIMM;
        bus.illegal = !decode_ok;
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = ALUSRCB_IMM;
      end
      MEMRD:  bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_c   = 1'b1;
      end
      MEMWR: begin
        bus.iord   = 1'b1;
        memwrite_c = 1'b1;
      end
      EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
      end
      ALUWB: begin
        bus.regdst = 1'b1;
        regwrite_c = 1'b1;
      end
      BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = PCSRC_ALUOUT;
        pcen_c      = (bus.op == OP_BEQ) ? bus.zero : !bus.zero;
      end
      IMMEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = ALUSRCB_IMM;
        bus.zeroext = (bus.op == OP_ORI);
        aluop       = (bus.op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
      end
      IMMWB: begin
        regwrite_c  = 1'b1;
        bus.zeroext = (bus.op == OP_ORI);
      end
      JUMP: begin
        bus.pcsrc = PCSRC_JUMP;
        pcen_c    = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write enables are suppressed for the whole time reset is held low
  assign bus.pcen       = pcen_c & reset;
  assign bus.irwrite    = irwrite_c & reset;
  assign bus.memwrite   = memwrite_c & reset;
  assign bus.regwrite   = regwrite_c & reset;
  assign bus.alucontrol = alu_ctl;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed testbench for mips_mc_controller.
// The memready stall scenario runs only when MIPS_MC_MEMWAIT_EN is defined.
module tb_mips_mc_controller;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mips_mc_controller_if #(.STATE_W(4)) bus();

  mips_mc_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op = OP_LW;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
`ifdef MIPS_MC_MEMWAIT_EN
    bus.memready = 1'b1;
`endif
    tick();
    tick();
    total++;
    if (bus.state !== 4'd0) begin
      bad++; $display("FAIL reset_state got=%0d want=0", bus.state);
    end
    total++;
    if ({bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite} !== 4'b0000) begin
      bad++; $display("FAIL reset_enables got=%b want=0000",
                      {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite});
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.pcen, bus.irwrite, bus.alusrcb} !== 4'b1101) begin
      bad++; $display("FAIL fetch_outputs got=%b want=1101", {bus.pcen, bus.irwrite, bus.alusrcb});
    end
    $display("reset: released, state=%0d", bus.state);
  endtask

  task automatic test_lw();
    int   exp_st[6]   = '{0, 1, 2, 3, 4, 0};
    logic exp_pcen[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_wb[6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.op = OP_LW;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bus.state !== 4'(exp_st[i])) begin
        bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, bus.state, exp_st[i]);
      end
      total++;
      if (bus.pcen !== exp_pcen[i]) begin
        bad++; $display("FAIL lw_pcen[%0d] got=%b want=%b", i, bus.pcen, exp_pcen[i]);
      end
      total++;
      if ({bus.memtoreg, bus.regwrite} !== {exp_wb[i], exp_wb[i]}) begin
        bad++; $display("FAIL lw_wb[%0d] got=%b want=%b", i, {bus.memtoreg, bus.regwrite},
                        {exp_wb[i], exp_wb[i]});
      end
      if (i < 5) tick();
    end
    $display("lw: sequence done");
  endtask

  task automatic test_rtype();
    logic [5:0] fn[4]  = '{FN_ADD, FN_SUB, FN_AND, FN_OR};
    logic [2:0] exp[4] = '{3'b010, 3'b110, 3'b000, 3'b001};
    bus.op = OP_RTYPE;
    bus.funct = FN_SLT;
    tick();
    total++;
    if ({bus.state, bus.illegal} !== {4'd1, 1'b0}) begin
      bad++; $display("FAIL slt_decode got=%0d/%b want=1/0", bus.state, bus.illegal);
    end
    tick();
    total++;
    if ({bus.state, bus.alucontrol, bus.alusrca, bus.alusrcb} !== {4'd6, 3'b111, 1'b1, 2'b00}) begin
      bad++; $display("FAIL slt_execute got=%0d/%b/%b/%b want=6/111/1/00",
                      bus.state, bus.alucontrol, bus.alusrca, bus.alusrcb);
    end
    tick();
    total++;
    if ({bus.state, bus.regdst, bus.regwrite, bus.memtoreg} !== {4'd7, 3'b110}) begin
      bad++; $display("FAIL slt_aluwb got=%0d/%b want=7/110",
                      bus.state, {bus.regdst, bus.regwrite, bus.memtoreg});
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin
      bad++; $display("FAIL slt_return got=%0d want=0", bus.state);
    end
    $display("rtype: slt done");
    for (int i = 0; i < 4; i++) begin
      bus.funct = fn[i];
      tick();
      tick();
      total++;
      if ({bus.state, bus.alucontrol} !== {4'd6, exp[i]}) begin
        bad++; $display("FAIL rtype_alu[%0d] got=%0d/%b want=6/%b", i, bus.state, bus.alucontrol, exp[i]);
      end
      tick();
      tick();
      $display("rtype: funct=%b done", fn[i]);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[4]   = '{OP_BEQ, OP_BNE, OP_BNE, OP_BEQ};
    logic       zs[4]    = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       expen[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.op = ops[i];
      bus.zero = zs[i];
      tick();
      tick();
      total++;
      if ({bus.state, bus.pcen, bus.pcsrc, bus.alucontrol} !== {4'd8, expen[i], 2'b01, 3'b110}) begin
        bad++; $display("FAIL branch[%0d] got=%0d/%b/%b/%b want=8/%b/01/110",
                        i, bus.state, bus.pcen, bus.pcsrc, bus.alucontrol, expen[i]);
      end
      tick();
      total++;
      if (bus.state !== 4'd0) begin
        bad++; $display("FAIL branch_return[%0d] got=%0d want=0", i, bus.state);
      end
      $display("branch: op=%b zero=%b pcen=%b", ops[i], zs[i], bus.pcen);
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0] ops[2]  = '{OP_ORI, OP_ADDI};
    logic       zx[2]   = '{1'b1, 1'b0};
    logic [2:0] alu[2]  = '{3'b001, 3'b010};
    for (int i = 0; i < 2; i++) begin
      bus.op = ops[i];
      tick();
      tick();
      total++;
      if ({bus.state, bus.zeroext, bus.alucontrol, bus.alusrcb, bus.alusrca} !==
          {4'd9, zx[i], alu[i], 2'b10, 1'b1}) begin
        bad++; $display("FAIL immexec[%0d] got=%0d/%b/%b/%b want=9/%b/%b/10",
                        i, bus.state, bus.zeroext, bus.alucontrol, bus.alusrcb, zx[i], alu[i]);
      end
      tick();
      total++;
      if ({bus.state, bus.regwrite, bus.regdst, bus.memtoreg, bus.zeroext} !==
          {4'd10, 3'b100, zx[i]}) begin
        bad++; $display("FAIL immwb[%0d] got=%0d/%b want=10/100%b", i, bus.state,
                        {bus.regwrite, bus.regdst, bus.memtoreg, bus.zeroext}, zx[i]);
      end
      tick();
      $display("imm: op=%b done", ops[i]);
    end
  endtask

  task automatic test_sw_jump();
    bus.op = OP_SW;
    tick();
    tick();
    total++;
    if ({bus.state, bus.alusrca, bus.alusrcb} !== {4'd2, 3'b110}) begin
      bad++; $display("FAIL sw_memadr got=%0d/%b want=2/110", bus.state, {bus.alusrca, bus.alusrcb});
    end
    tick();
    total++;
    if ({bus.state, bus.memwrite, bus.iord, bus.regwrite} !== {4'd5, 3'b110}) begin
      bad++; $display("FAIL sw_memwr got=%0d/%b want=5/110", bus.state,
                      {bus.memwrite, bus.iord, bus.regwrite});
    end
    tick();
    total++;
    if ({bus.state, bus.memwrite} !== {4'd0, 1'b0}) begin
      bad++; $display("FAIL sw_return got=%0d/%b want=0/0", bus.state, bus.memwrite);
    end
    $display("sw: done");
    bus.op = OP_J;
    tick();
    tick();
    total++;
    if ({bus.state, bus.pcsrc, bus.pcen} !== {4'd11, 2'b10, 1'b1}) begin
      bad++; $display("FAIL jump got=%0d/%b/%b want=11/10/1", bus.state, bus.pcsrc, bus.pcen);
    end
    tick();
    $display("j: done");
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2] = '{6'b111111, OP_RTYPE};
    logic [5:0] fns[2] = '{FN_ADD, 6'b000000};
    for (int i = 0; i < 2; i++) begin
      bus.op = ops[i];
      bus.funct = fns[i];
      tick();
      total++;
      if ({bus.state, bus.illegal, bus.regwrite, bus.memwrite} !== {4'd1, 3'b100}) begin
        bad++; $display("FAIL illegal_decode[%0d] got=%0d/%b want=1/100", i, bus.state,
                        {bus.illegal, bus.regwrite, bus.memwrite});
      end
      tick();
      total++;
      if ({bus.state, bus.illegal, bus.regwrite, bus.memwrite} !== {4'd0, 3'b000}) begin
        bad++; $display("FAIL illegal_next[%0d] got=%0d/%b want=0/000", i, bus.state,
                        {bus.illegal, bus.regwrite, bus.memwrite});
      end
      $display("illegal: op=%b funct=%b trapped", ops[i], fns[i]);
    end
  endtask

  task automatic test_reset_mid();
    bus.op = OP_SW;
    tick();
    tick();
    tick();
    total++;
    if ({bus.state, bus.memwrite} !== {4'd5, 1'b1}) begin
      bad++; $display("FAIL midrst_pre got=%0d/%b want=5/1", bus.state, bus.memwrite);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.state, bus.memwrite} !== {4'd0, 1'b0}) begin
      bad++; $display("FAIL midrst_now got=%0d/%b want=0/0", bus.state, bus.memwrite);
    end
    tick();
    total++;
    if ({bus.state, bus.pcen, bus.irwrite} !== {4'd0, 2'b00}) begin
      bad++; $display("FAIL midrst_hold got=%0d/%b want=0/00", bus.state, {bus.pcen, bus.irwrite});
    end
    reset = 1'b1;
    bus.op = OP_J;
    tick();
    total++;
    if (bus.state !== 4'd1) begin
      bad++; $display("FAIL midrst_release got=%0d want=1", bus.state);
    end
    tick();
    tick();
    $display("reset_mid: aborted sw");
  endtask

`ifdef MIPS_MC_MEMWAIT_EN
  task automatic test_memwait();
    bus.op = OP_LW;
    bus.memready = 1'b0;
    #1;
    total++;
    if ({bus.pcen, bus.irwrite} !== 2'b00) begin
      bad++; $display("FAIL wait_fetch got=%b want=00", {bus.pcen, bus.irwrite});
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin
      bad++; $display("FAIL wait_fetch_hold got=%0d want=0", bus.state);
    end
    bus.memready = 1'b1;
    tick();
    tick();
    tick();
    bus.memready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({bus.state, bus.iord} !== {4'd3, 1'b1}) begin
        bad++; $display("FAIL wait_memrd[%0d] got=%0d/%b want=3/1", i, bus.state, bus.iord);
      end
      if (i == 3) bus.memready = 1'b1;
      tick();
    end
    total++;
    if (bus.state !== 4'd4) begin
      bad++; $display("FAIL wait_memwb got=%0d want=4", bus.state);
    end
    tick();
    $display("memwait: lw with stalls done");
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_imm();
    test_sw_jump();
    test_illegal();
    test_reset_mid();
`ifdef MIPS_MC_MEMWAIT_EN
    test_memwait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
